// File: rtl/sram_bist.sv
// Write/read-back self-test for one asynchronous 32-bit SRAM bank; reports pass/fail and first bad word.
// Define SRAM_BIST_INV_PASS_EN to add a second pass using the inverted pattern.
module sram_bist #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe,
    input  logic [31:0]       ram_data_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [31:0]       fail_data
);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_HOLD, TURN, RD_ACCESS, DONE
    } state_t;

    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       pat_mask;
    logic [31:0]       exp_word;

    function automatic logic [31:0] pattern(input logic [ADDR_W-1:0] a);
        return 32'(a) ^ 32'hA5A5_A5A5;
    endfunction

`ifdef SRAM_BIST_INV_PASS_EN
    logic inv_reg;      // second (inverted) pass in progress
    logic turn_wr_reg;  // next TURN leads into writes rather than reads
    assign pat_mask = {32{inv_reg}};
`else
    assign pat_mask = 32'h0;
`endif

    assign addr_next = ram_addr + ADDR_W'(1);
    assign exp_word  = pattern(ram_addr) ^ pat_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ram_addr    <= '0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_data_o  <= '0;
            ram_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
`ifdef SRAM_BIST_INV_PASS_EN
            inv_reg     <= 1'b0;
            turn_wr_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg   <= WR_SETUP;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_addr   <= '0;
                        fail_data   <= '0;
                        ram_ce_n    <= 1'b0;
                        ram_oe_n    <= 1'b1;
                        ram_we_n    <= 1'b1;
                        ram_addr    <= '0;
                        ram_data_oe <= 1'b1;
                        ram_data_o  <= pattern('0);
`ifdef SRAM_BIST_INV_PASS_EN
                        inv_reg     <= 1'b0;
                        turn_wr_reg <= 1'b0;
`endif
                    end
                end
                WR_SETUP: begin
                    state_reg <= WR_PULSE;
                    ram_we_n  <= 1'b0;
                    cnt_reg   <= '0;
                end
                WR_PULSE: begin
                    if (cnt_reg == PULSE_LAST) begin
                        state_reg <= WR_HOLD;
                        ram_we_n  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    if (ram_addr == LAST_ADDR) begin
                        state_reg   <= TURN;
                        ram_addr    <= '0;
                        ram_data_oe <= 1'b0;
                    end else begin
                        state_reg  <= WR_SETUP;
                        ram_addr   <= addr_next;
                        ram_data_o <= pattern(addr_next) ^ pat_mask;
                    end
                end
                TURN: begin
`ifdef SRAM_BIST_INV_PASS_EN
                    if (turn_wr_reg) begin
                        state_reg   <= WR_SETUP;
                        turn_wr_reg <= 1'b0;
                        ram_data_oe <= 1'b1;
                        ram_data_o  <= ~pattern('0);
                    end else begin
                        state_reg <= RD_ACCESS;
                        ram_oe_n  <= 1'b0;
                        cnt_reg   <= '0;
                    end
`else
                    state_reg <= RD_ACCESS;
                    ram_oe_n  <= 1'b0;
                    cnt_reg   <= '0;
`endif
                end
                RD_ACCESS: begin
                    if (cnt_reg != RD_LAST) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end else if (ram_data_i != exp_word) begin
                        fail_addr <= ram_addr;
                        fail_data <= ram_data_i;
                        pass      <= 1'b0;
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        ram_ce_n  <= 1'b1;
                        ram_oe_n  <= 1'b1;
                    end else if (ram_addr != LAST_ADDR) begin
                        ram_addr <= addr_next;
                        cnt_reg  <= '0;
`ifdef SRAM_BIST_INV_PASS_EN
                    end else if (!inv_reg) begin
                        inv_reg     <= 1'b1;
                        turn_wr_reg <= 1'b1;
                        ram_addr    <= '0;
                        ram_oe_n    <= 1'b1;
                        state_reg   <= TURN;
`endif
                    end else begin
                        pass      <= 1'b1;
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        ram_ce_n  <= 1'b1;
                        ram_oe_n  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bist.sv
// Directed bench for sram_bist with an ideal SRAM model, optional stuck-at fault and queue scoreboards.
module tb_sram_bist;

    localparam int AW = 4;
`ifdef SRAM_BIST_INV_PASS_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    typedef struct {
        int          lat;
        logic        pass;
        logic [31:0] fa;
        logic [31:0] fd;
        int          rds;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [AW-1:0] ram_addr, fail_addr;
    logic          ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;
    logic [31:0]   ram_data_o, ram_data_i, fail_data;
    logic          busy, done, pass;

    logic [31:0] mem [16];
    bit          fault_en = 1'b0;
    int          cyc = 0, total = 0, bad = 0;
    int          ce_low = 0, rd_cnt = 0, rd_max = 0;
    logic        prev_we_n = 1'b1, prev_oe_n = 1'b1;
    logic [AW-1:0] prev_addr = '0;
    exp_t        exp_q[$];
    wr_t         wq[$];

    sram_bist #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .ram_data_o(ram_data_o), .ram_data_oe(ram_data_oe),
        .ram_data_i(ram_data_i), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal asynchronous SRAM; optional bit 7 stuck at 0 at address 5
    always @(posedge clk)
        if (!ram_ce_n && !ram_we_n)
            mem[ram_addr] <= (fault_en && ram_addr == 4'd5) ? (ram_data_o & ~32'h80) : ram_data_o;
    assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr] : 32'h0;

    function automatic logic [31:0] pat(input int a);
        return 32'(a) ^ 32'hA5A5_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Per-cycle protocol checks and write/read monitors
    always @(negedge clk) begin
        if (rst_n) begin
            check("oe_excl", {31'b0, ram_data_oe & ~ram_oe_n}, 32'h0);
            check("we_drv", {31'b0, ~ram_we_n & ~ram_data_oe}, 32'h0);
            check("ce_busy", {31'b0, ram_ce_n}, {31'b0, !busy});
            if (!ram_ce_n) ce_low++;
            if (!ram_we_n && prev_we_n) begin
                total++;
                assert (wq.size() != 0) else begin
                    bad++;
                    $error("FAIL wr_unexpected: observed addr=%0d expected=no write", ram_addr);
                end
                if (wq.size() != 0) begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_addr", 32'(ram_addr), w.addr);
                    check("wr_data", ram_data_o, w.data);
                end
            end
            if (!ram_oe_n && (prev_oe_n || ram_addr != prev_addr)) begin
                rd_cnt++;
                if (int'(ram_addr) > rd_max) rd_max = int'(ram_addr);
            end
        end
        prev_we_n = ram_we_n;
        prev_oe_n = ram_oe_n;
        prev_addr = ram_addr;
    end

    task automatic push_writes(input bit inv);
        for (int a = 0; a < 16; a++) begin
            wr_t w;
            w.addr = 32'(a);
            w.data = inv ? ~pat(a) : pat(a);
            wq.push_back(w);
        end
    endtask

    task automatic pulse_start(input bit hold, output int k);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        ce_low = 0;
        rd_cnt = 0;
        rd_max = 0;
        if (!hold) start = 1'b0;
    endtask

    task automatic run_test(input bit faulty, input bit hold);
        exp_t e;
        int   k;
        push_writes(1'b0);
        if (INV && !faulty) push_writes(1'b1);
        e.lat  = faulty ? 61 : (INV ? 163 : 81);
        e.pass = !faulty;
        e.fa   = faulty ? 32'd5 : 32'd0;
        e.fd   = faulty ? 32'hA5A5_A520 : 32'h0;
        e.rds  = faulty ? 6 : (INV ? 32 : 16);
        exp_q.push_back(e);
        pulse_start(hold, k);
        while (!done && (cyc - k) < 1000) @(negedge clk);
        check("done_seen", {31'b0, done}, 32'h1);
        e = exp_q.pop_front();
        check("done_latency", 32'(cyc - k), 32'(e.lat));
        check("pass", {31'b0, pass}, {31'b0, e.pass});
        check("fail_addr", 32'(fail_addr), e.fa);
        check("fail_data", fail_data, e.fd);
        check("ce_low_cycles", 32'(ce_low), 32'(e.lat));
        check("read_count", 32'(rd_cnt), 32'(e.rds));
        check("writes_left", 32'(wq.size()), 32'h0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ce_n", {31'b0, ram_ce_n}, 32'h1);
        check("rst_oe_n", {31'b0, ram_oe_n}, 32'h1);
        check("rst_we_n", {31'b0, ram_we_n}, 32'h1);
        check("rst_data_oe", {31'b0, ram_data_oe}, 32'h0);
        check("rst_addr", 32'(ram_addr), 32'h0);
        check("rst_data_o", ram_data_o, 32'h0);
        check("rst_flags", {29'b0, busy, done, pass}, 32'h0);
        check("rst_fail_addr", 32'(fail_addr), 32'h0);
        check("rst_fail_data", fail_data, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test(1'b0, 1'b0);
        $display("run clean: pass=%0b done=%0b", pass, done);
        check("mem3", mem[3], INV ? 32'h5A5A_5A59 : 32'hA5A5_A5A6);

        fault_en = 1'b1;
        run_test(1'b1, 1'b0);
        $display("run fault: pass=%0b fail_addr=%0d fail_data=%h", pass, fail_addr, fail_data);
        check("max_read_addr", 32'(rd_max), 32'd5);
        fault_en = 1'b0;

        // Abort during a write pulse
        push_writes(1'b0);
        pulse_start(1'b0, k);
        while (!(ram_addr == 4'd2 && !ram_we_n) && (cyc - k) < 200) @(negedge clk);
        check("wr_pulse_seen", {31'b0, ram_we_n}, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_strobes", {28'b0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 32'hE);
        check("abort_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        wq.delete();
        $display("run abort: busy=%0b we_n=%0b", busy, ram_we_n);

        run_test(1'b0, 1'b0);
        $display("run after abort: pass=%0b", pass);

        // start held high: no restart while busy, restart out of DONE
        run_test(1'b0, 1'b1);
        @(negedge clk);
        check("restart_busy", {31'b0, busy}, 32'h1);
        check("restart_done_clr", {31'b0, done}, 32'h0);
        $display("run held start: restart busy=%0b done=%0b", busy, done);
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wq.delete();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_bist.md
# sram_bist

Self-test engine for one asynchronous 32-bit board SRAM bank (base or ext), placed between the PLL/reset controller and the SRAM pins in the board bring-up top. After reset release it writes an address-derived pattern to every word, reads it back and compares each word. It reports pass/fail and the first failing address and data, which the top maps onto LEDs. The top instantiates one copy per bank and builds the tristate from `ram_data_o`/`ram_data_oe`.

## Interface
- `ADDR_W`, 20: SRAM word-address width; the test covers 2^ADDR_W words.
- `WAIT_CYCLES`, 2: `we_n` low-pulse length in cycles, and read access time is WAIT_CYCLES+1 cycles; minimum 1.
- `clk`  in  1  system clock (PLL c0).
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level or pulse; sampled in IDLE/DONE.
- `ram_addr`  out  ADDR_W  SRAM word address.
- `ram_ce_n`  out  1  chip enable, active low.
- `ram_oe_n`  out  1  output enable, active low.
- `ram_we_n`  out  1  write enable, active low.
- `ram_data_o`  out  32  write data.
- `ram_data_oe`  out  1  1 = drive `ram_data_o` onto the pins.
- `ram_data_i`  in  32  pin data.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished, held until next start.
- `pass`  out  1  valid when `done`; 1 = no mismatch.
- `fail_addr`  out  ADDR_W  first mismatching address.
- `fail_data`  out  32  data read at `fail_addr`.

## Operation
- Pattern: P(a) = {(32-ADDR_W)'b0, a} XOR 32'hA5A5_A5A5. Inverted pass uses ~P(a).
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, TURN, RD_ACCESS, DONE.
- IDLE/DONE + `start`=1: clear `done`, `pass`, `fail_*`; set `busy`; `ram_addr`=0; go to WR_SETUP.
- WR_SETUP (1 cycle): `ram_data_oe`=1, data=P(addr), `we_n`=1 -> WR_PULSE.
- WR_PULSE (WAIT_CYCLES cycles): `we_n`=0 -> WR_HOLD.
- WR_HOLD (1 cycle): `we_n`=1, data still driven. Not the last address: addr+1 -> WR_SETUP. Last address: addr=0 -> TURN.
- TURN (1 cycle): `ram_data_oe`=0, `oe_n`=1 -> RD_ACCESS.
- RD_ACCESS (WAIT_CYCLES+1 cycles): `oe_n`=0; `ram_data_i` is sampled on the final cycle.
  - Mismatch: capture `fail_addr`/`fail_data`, `pass`=0 -> DONE (the test stops).
  - Match, not the last address: addr+1, stay in RD_ACCESS.
  - Match, last address: `pass`=1 -> DONE, or to the inverted pass (see Configuration).
- `ram_ce_n`=0 exactly while `busy`=1.
- `ram_data_oe`=1 and `ram_oe_n`=0 are never asserted in the same cycle.
- DONE: `busy`=0, `done`=1, all SRAM strobes inactive.
- `start` while `busy` is ignored.
- Address increment never wraps mid-phase. The last address is 2^ADDR_W-1.

## Timing
- Reset values on a clock edge with `rst_n`=0: `ram_ce_n`=`ram_oe_n`=`ram_we_n`=1, `ram_data_oe`=0, `ram_addr`=0, `ram_data_o`=0, `busy`=`done`=`pass`=0, `fail_addr`=0, `fail_data`=0; state IDLE.
- Reset mid-write: `we_n` rises on the reset edge; the SRAM contents are don't-care.
- All outputs are registered.
- Cycle counts per pass:
  - Write cost per address: WAIT_CYCLES+2 cycles.
  - Read cost per address: WAIT_CYCLES+1 cycles.
  - Total: 2^ADDR_W·(2·WAIT_CYCLES+3)+1 cycles.
- `start` sampled at edge k: first WR_SETUP is cycle k+1, and `done` rises one cycle after the final compare.

## Configuration
- `SRAM_BIST_INV_PASS_EN` defined: after a clean first pass, go to TURN, then repeat write/read with ~P(a) (a second TURN precedes the reads). `pass`=1 only if both passes are clean.
- `SRAM_BIST_INV_PASS_EN` undefined: single pass, and the inverted-pass logic is absent.

## Test plan
- ADDR_W=4, WAIT_CYCLES=1, ideal SRAM model, macro off, `start` at edge k -> 16 writes with `we_n` low 1 cycle each; `done`=1, `pass`=1 first at cycle k+82; `ram_ce_n`=0 for cycles k+1..k+81.
- Same config, macro on -> `done` at k+164; the word at address 3 is written 32'hA5A5_A5A6 then 32'h5A5A_5A59.
- Model bit 7 stuck at 0 at address 5 -> `pass`=0, `fail_addr`=5, `fail_data`=P(5) with bit 7 cleared; no read of address 6 occurs.
- Every cycle -> never `ram_data_oe`=1 with `ram_oe_n`=0; never `ram_we_n`=0 with `ram_data_oe`=0.
- `rst_n`=0 during WR_PULSE -> next edge: all strobes high, `busy`=0. After release, `start` runs a full clean test.
- `start` held high through the run -> no restart while busy. In DONE it restarts next cycle with `done` cleared.
